// File: rtl/wb_pkg.sv
// Shared encodings for the W stage: write-back source select, load types
// and the link-address offset used by jump-and-link instructions.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC8  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_type_e;

    localparam logic [31:0] PC8_OFFSET = 32'd8;
    localparam int          NUM_REGS   = 32;

endpackage

// File: rtl/w_load_ext.sv
// Combinational load extraction: picks the addressed byte/halfword out of an
// aligned memory word and sign- or zero-extends it to 32 bits.
module w_load_ext
    import wb_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  ld_type_i,
    input  logic [1:0]  byte_off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (byte_off_i)
            2'd0:    byteSel = word_i[7:0];
            2'd1:    byteSel = word_i[15:8];
            2'd2:    byteSel = word_i[23:16];
            default: byteSel = word_i[31:24];
        endcase
        // Halfword loads are assumed aligned, so only bit 1 of the offset matters.
        halfSel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (ld_type_i)
            LD_B:    data_o = {{24{byteSel[7]}}, byteSel};
            LD_BU:   data_o = {24'd0, byteSel};
            LD_H:    data_o = {{16{halfSel[15]}}, halfSel};
            LD_HU:   data_o = {16'd0, halfSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/w_writeback_ctrl.sv
// W-stage GRF writer: registers the M->W payload, selects the write-back value
// and keeps a per-register pending-write scoreboard for D-stage stall logic.
module w_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int          CNT_W    = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_we,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wb_sel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mem_word,
    input  logic [2:0]  m_ld_type,
    input  logic [1:0]  m_byte_off,
    input  logic        d_issue,
    input  logic [4:0]  d_issue_a3,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic        busy_rs,
    output logic        busy_rt,
    output logic        sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      loadData;
    logic [31:0]      wdNext;
    logic             weNext;
    logic             incValid;

    logic             grf_we_q;
    logic [4:0]       grf_a3_q;
    logic [31:0]      grf_wd_q;
    logic [31:0]      grf_pc_q;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [CNT_W-1:0] rsLeft;
    logic [CNT_W-1:0] rtLeft;

    w_load_ext u_load_ext (
        .word_i     (m_mem_word),
        .ld_type_i  (m_ld_type),
        .byte_off_i (m_byte_off),
        .data_o     (loadData)
    );

    always_comb begin
        weNext = m_valid & m_we & (m_a3 != 5'd0);
        case (m_wb_sel)
            WB_MEM:  wdNext = loadData;
            WB_PC8:  wdNext = m_pc + PC8_OFFSET;
            default: wdNext = m_alu;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we_q <= 1'b0;
            grf_a3_q <= 5'd0;
            grf_wd_q <= 32'd0;
            grf_pc_q <= PC_RESET;
        end else begin
            grf_we_q <= weNext;
            grf_a3_q <= weNext ? m_a3 : 5'd0;
            grf_wd_q <= wdNext;
            grf_pc_q <= m_pc;
        end
    end

    assign incValid = d_issue & (d_issue_a3 != 5'd0);

    // An issue and a commit hitting the same register cancel; saturation and
    // underflow leave the counter alone and raise the sticky error instead.
    always_comb begin
        sb_err_d = sb_err_q;
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic incHit;
            logic decHit;
            incHit = incValid && (d_issue_a3 == 5'(r));
            decHit = grf_we_q && (grf_a3_q == 5'(r));
            if (incHit && !decHit) begin
                if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (decHit && !incHit) begin
                if (cnt_q[r] == '0) sb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // The GRF forwards the write happening this cycle, so it is not a hazard.
    always_comb begin
        rsLeft  = cnt_q[d_rs] - CNT_W'(grf_we_q && (grf_a3_q == d_rs));
        rtLeft  = cnt_q[d_rt] - CNT_W'(grf_we_q && (grf_a3_q == d_rt));
        busy_rs = (d_rs != 5'd0) && (rsLeft != '0);
        busy_rt = (d_rt != 5'd0) && (rtLeft != '0);
    end

    assign grf_we = grf_we_q;
    assign grf_a3 = grf_a3_q;
    assign grf_wd = grf_wd_q;
    assign grf_pc = grf_pc_q;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_w_writeback_ctrl.sv
// Self-checking bench for w_writeback_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_w_writeback_ctrl;
    import wb_pkg::*;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = 5'd0;
    logic [1:0]  m_wb_sel = 2'd0;
    logic [31:0] m_alu = 32'd0;
    logic [31:0] m_mem_word = 32'd0;
    logic [2:0]  m_ld_type = 3'd0;
    logic [1:0]  m_byte_off = 2'd0;
    logic        d_issue = 1'b0;
    logic [4:0]  d_issue_a3 = 5'd0;
    logic [4:0]  d_rs = 5'd0;
    logic [4:0]  d_rt = 5'd0;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic        busy_rs;
    logic        busy_rt;
    logic        sb_err;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    bit          mdlWe = 1'b0;
    int          mdlA3 = 0;
    logic [31:0] mdlWd = 32'd0;
    logic [31:0] mdlPc = 32'h0000_3000;
    int          mdlCnt [32];
    bit          mdlErr = 1'b0;
    int          incReg;
    int          decReg;

    logic [2:0]  ldTab  [4] = '{LD_B, LD_BU, LD_H, LD_HU};
    logic [1:0]  offTab [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
    logic [31:0] expTab [4] = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8070, 32'h0000_F0A1};

    w_writeback_ctrl #(.CNT_W(CNT_W), .PC_RESET(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_pc       (m_pc),
        .m_we       (m_we),
        .m_a3       (m_a3),
        .m_wb_sel   (m_wb_sel),
        .m_alu      (m_alu),
        .m_mem_word (m_mem_word),
        .m_ld_type  (m_ld_type),
        .m_byte_off (m_byte_off),
        .d_issue    (d_issue),
        .d_issue_a3 (d_issue_a3),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .grf_we     (grf_we),
        .grf_a3     (grf_a3),
        .grf_wd     (grf_wd),
        .grf_pc     (grf_pc),
        .busy_rs    (busy_rs),
        .busy_rt    (busy_rt),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expWd(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] pc, input logic [31:0] mem,
                                          input logic [2:0] ld, input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] loaded;
        sh = mem >> (8 * int'(off));
        case (ld)
            3'd1:    loaded = {{24{sh[7]}}, sh[7:0]};
            3'd2:    loaded = {24'd0, sh[7:0]};
            3'd3: begin
                sh = mem >> (16 * int'(off[1]));
                loaded = {{16{sh[15]}}, sh[15:0]};
            end
            3'd4: begin
                sh = mem >> (16 * int'(off[1]));
                loaded = {16'd0, sh[15:0]};
            end
            default: loaded = mem;
        endcase
        if (sel == 2'd1)      return loaded;
        else if (sel == 2'd2) return pc + 32'd8;
        else                  return alu;
    endfunction

    function automatic bit modelBusy(input logic [4:0] r);
        int left;
        if (r == 5'd0) return 1'b0;
        left = (mdlCnt[r] - ((mdlWe && mdlA3 == int'(r)) ? 1 : 0)) & CMAX;
        return left != 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdlWe = 1'b0;
            mdlA3 = 0;
            mdlWd = 32'd0;
            mdlPc = 32'h0000_3000;
            mdlErr = 1'b0;
            for (int r = 0; r < 32; r++) mdlCnt[r] = 0;
        end else begin
            incReg = (d_issue && d_issue_a3 != 5'd0) ? int'(d_issue_a3) : 0;
            decReg = mdlWe ? mdlA3 : 0;
            if (incReg != decReg) begin
                if (incReg != 0) begin
                    if (mdlCnt[incReg] == CMAX) mdlErr = 1'b1;
                    else mdlCnt[incReg]++;
                end
                if (decReg != 0) begin
                    if (mdlCnt[decReg] == 0) mdlErr = 1'b1;
                    else mdlCnt[decReg]--;
                end
            end
            mdlWe = m_valid && m_we && (m_a3 != 5'd0);
            mdlA3 = mdlWe ? int'(m_a3) : 0;
            mdlWd = expWd(m_wb_sel, m_alu, m_pc, m_mem_word, m_ld_type, m_byte_off);
            mdlPc = m_pc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("mdl_grf_we", {31'd0, grf_we}, {31'd0, mdlWe});
        checkOutput("mdl_grf_a3", {27'd0, grf_a3}, 32'(mdlA3));
        checkOutput("mdl_sb_err", {31'd0, sb_err}, {31'd0, mdlErr});
        checkOutput("mdl_busy_rs", {31'd0, busy_rs}, {31'd0, modelBusy(d_rs)});
        checkOutput("mdl_busy_rt", {31'd0, busy_rt}, {31'd0, modelBusy(d_rt)});
        if (mdlWe) begin
            checkOutput("mdl_grf_wd", grf_wd, mdlWd);
            checkOutput("mdl_grf_pc", grf_pc, mdlPc);
        end
    end

    task automatic applyStimulus(input logic valid, input logic we, input logic [4:0] a3,
                                 input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [2:0] ld,
                                 input logic [1:0] off, input logic [31:0] pc,
                                 input logic iss, input logic [4:0] issA3,
                                 input logic [4:0] rs, input logic [4:0] rt);
        m_valid    = valid;
        m_we       = we;
        m_a3       = a3;
        m_wb_sel   = sel;
        m_alu      = alu;
        m_mem_word = mem;
        m_ld_type  = ld;
        m_byte_off = off;
        m_pc       = pc;
        d_issue    = iss;
        d_issue_a3 = issA3;
        d_rs       = rs;
        d_rt       = rt;
    endtask

    task automatic idleWith(input logic iss, input logic [4:0] issA3, input logic [4:0] rs, input logic [4:0] rt);
        applyStimulus(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, LD_W, 2'd0, 32'd0, iss, issA3, rs, rt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idleWith(1'b0, 5'd0, 5'd0, 5'd0);
        #2 reset = 1'b0;
        step();
        step();
        checkOutput("rst_we", {31'd0, grf_we}, 32'd0);
        checkOutput("rst_a3", {27'd0, grf_a3}, 32'd0);
        checkOutput("rst_wd", grf_wd, 32'd0);
        checkOutput("rst_pc", grf_pc, 32'h0000_3000);
        checkOutput("rst_err", {31'd0, sb_err}, 32'd0);
        reset = 1'b1;

        // ALU write-back, one cycle latency
        applyStimulus(1'b1, 1'b1, 5'd5, WB_ALU, 32'hDEAD_BEEF, 32'd0, LD_W, 2'd0, 32'h3000, 1'b1, 5'd5, 5'd0, 5'd0);
        step();
        checkOutput("t1_we", {31'd0, grf_we}, 32'd1);
        checkOutput("t1_a3", {27'd0, grf_a3}, 32'd5);
        checkOutput("t1_wd", grf_wd, 32'hDEAD_BEEF);
        checkOutput("t1_pc", grf_pc, 32'h0000_3000);

        // Load extraction and extension
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd10, WB_MEM, 32'd0, 32'h8070_F0A1, ldTab[i], offTab[i], 32'h100, 1'b1, 5'd10, 5'd0, 5'd0);
            step();
            checkOutput("t2_ld_wd", grf_wd, expTab[i]);
        end

        // PC+8 wraps; writes to register 0 are suppressed
        applyStimulus(1'b1, 1'b1, 5'd11, WB_PC8, 32'd0, 32'd0, LD_W, 2'd0, 32'hFFFF_FFFC, 1'b1, 5'd11, 5'd0, 5'd0);
        step();
        checkOutput("t3_pc8_wd", grf_wd, 32'h0000_0004);
        checkOutput("t3_pc8_a3", {27'd0, grf_a3}, 32'd11);
        applyStimulus(1'b1, 1'b1, 5'd0, WB_ALU, 32'h1234, 32'd0, LD_W, 2'd0, 32'h10, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        checkOutput("t3_r0_we", {31'd0, grf_we}, 32'd0);
        checkOutput("t3_r0_a3", {27'd0, grf_a3}, 32'd0);
        checkOutput("t3_err", {31'd0, sb_err}, 32'd0);

        // Scoreboard set, bypassed commit, clear and same-cycle cancel
        idleWith(1'b1, 5'd7, 5'd7, 5'd0);
        step();
        checkOutput("t4_busy_set", {31'd0, busy_rs}, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd7, WB_ALU, 32'h77, 32'd0, LD_W, 2'd0, 32'h20, 1'b0, 5'd0, 5'd7, 5'd0);
        step();
        idleWith(1'b0, 5'd0, 5'd7, 5'd0);
        checkOutput("t4_busy_commit", {31'd0, busy_rs}, 32'd0);
        step();
        checkOutput("t4_busy_clear", {31'd0, busy_rs}, 32'd0);
        idleWith(1'b1, 5'd7, 5'd7, 5'd0);
        step();
        applyStimulus(1'b1, 1'b1, 5'd7, WB_ALU, 32'h78, 32'd0, LD_W, 2'd0, 32'h24, 1'b0, 5'd0, 5'd7, 5'd0);
        step();
        idleWith(1'b1, 5'd7, 5'd7, 5'd0);
        checkOutput("t4_same_busy", {31'd0, busy_rs}, 32'd0);
        step();
        idleWith(1'b0, 5'd0, 5'd7, 5'd0);
        checkOutput("t4_same_hold", {31'd0, busy_rs}, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd7, WB_ALU, 32'h79, 32'd0, LD_W, 2'd0, 32'h28, 1'b0, 5'd0, 5'd7, 5'd0);
        step();
        idleWith(1'b0, 5'd0, 5'd7, 5'd0);
        step();
        checkOutput("t4_final_busy", {31'd0, busy_rs}, 32'd0);
        checkOutput("t4_final_err", {31'd0, sb_err}, 32'd0);

        // Underflow then overflow on register 9
        applyStimulus(1'b1, 1'b1, 5'd9, WB_ALU, 32'h99, 32'd0, LD_W, 2'd0, 32'h30, 1'b0, 5'd0, 5'd9, 5'd0);
        step();
        idleWith(1'b0, 5'd0, 5'd9, 5'd0);
        step();
        checkOutput("t5_underflow_err", {31'd0, sb_err}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idleWith(1'b1, 5'd9, 5'd9, 5'd0);
            step();
            if (i == 2) checkOutput("t5_err_before_sat", {31'd0, sb_err}, 32'd0);
        end
        idleWith(1'b0, 5'd0, 5'd9, 5'd0);
        checkOutput("t5_overflow_err", {31'd0, sb_err}, 32'd1);
        checkOutput("t5_sat_busy", {31'd0, busy_rs}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd9, WB_ALU, 32'h9, 32'd0, LD_W, 2'd0, 32'h40, 1'b0, 5'd0, 5'd9, 5'd0);
            step();
        end
        idleWith(1'b0, 5'd0, 5'd9, 5'd0);
        checkOutput("t5_drain_busy_commit", {31'd0, busy_rs}, 32'd0);
        step();
        checkOutput("t5_drain_busy", {31'd0, busy_rs}, 32'd0);
        checkOutput("t5_err_sticky", {31'd0, sb_err}, 32'd1);

        // Asynchronous reset mid-cycle with live state
        applyStimulus(1'b1, 1'b1, 5'd12, WB_ALU, 32'hA5A5, 32'd0, LD_W, 2'd0, 32'h400, 1'b1, 5'd12, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 1'b1, 5'd15, WB_ALU, 32'h5A5A, 32'd0, LD_W, 2'd0, 32'h404, 1'b1, 5'd20, 5'd20, 5'd12);
        step();
        idleWith(1'b0, 5'd0, 5'd20, 5'd15);
        checkOutput("t6_pre_busy_rs", {31'd0, busy_rs}, 32'd1);
        checkOutput("t6_pre_we", {31'd0, grf_we}, 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("t6_we", {31'd0, grf_we}, 32'd0);
        checkOutput("t6_a3", {27'd0, grf_a3}, 32'd0);
        checkOutput("t6_wd", grf_wd, 32'd0);
        checkOutput("t6_pc", grf_pc, 32'h0000_3000);
        checkOutput("t6_busy_rs", {31'd0, busy_rs}, 32'd0);
        checkOutput("t6_busy_rt", {31'd0, busy_rt}, 32'd0);
        checkOutput("t6_err", {31'd0, sb_err}, 32'd0);
        step();
        reset = 1'b1;

        // Randomized traffic over a small register window to force collisions
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 32'($urandom),
                          32'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if ((i % 250) == 249) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/w_writeback_ctrl.md
Name: w_writeback_ctrl

Overview:
- W-stage writer for the general register file (GRF).
- Registers the M→W pipeline payload, extracts and extends load data, and selects the write-back value.
- Drives the GRF write port (WE/A3/WD/PC) one cycle after M presents an instruction.
- Keeps a per-register pending-write scoreboard: set on D-stage issue, cleared on W commit. D-stage stall logic reads it.

Parameters:
- CNT_W, 2: width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1.
- PC_RESET, 32'h0000_3000: reset value of grf_pc.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_valid  in  1  M stage holds a real instruction (0 = bubble).
- m_pc  in  32  PC of the M instruction.
- m_we  in  1  M instruction writes the GRF.
- m_a3  in  5  destination register.
- m_wb_sel  in  2  write-back source: 0 ALU, 1 MEM, 2 PC8, 3 reserved (treated as ALU).
- m_alu  in  32  ALU result.
- m_mem_word  in  32  raw aligned data-memory word.
- m_ld_type  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; others treated as LW.
- m_byte_off  in  2  address bits [1:0].
- d_issue  in  1  D stage issues an instruction that will write d_issue_a3.
- d_issue_a3  in  5  destination register of the issuing instruction.
- d_rs  in  5  D-stage source register query.
- d_rt  in  5  D-stage source register query.
- grf_we  out  1  GRF write enable.
- grf_a3  out  5  GRF write address.
- grf_wd  out  32  GRF write data.
- grf_pc  out  32  PC of the committing instruction, for the write trace.
- busy_rs  out  1  d_rs has an uncommitted pending write.
- busy_rt  out  1  d_rt has an uncommitted pending write.
- sb_err  out  1  sticky flag: scoreboard overflow or underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - grf_we=0, grf_a3=0, grf_wd=0, grf_pc=PC_RESET.
  - All counters = 0; sb_err = 0.
  - Reset mid-operation discards in-flight state immediately.
- Pipeline register: at each posedge, capture the M payload.
  - grf_we <= m_valid & m_we & (m_a3 != 0).
  - grf_a3 <= m_a3 when that enable is 1, else 0.
  - Latency: M presentation → GRF outputs = 1 cycle. No stall input; W never stalls.
- grf_wd, computed before registering:
  - ALU source: m_alu.
  - PC8 source: m_pc + 8, wrapping modulo 2^32.
  - MEM source: load extension.
    - LW: the full word.
    - LB/LBU: byte at m_byte_off×8, sign-/zero-extended.
    - LH/LHU: halfword selected by m_byte_off[1]; m_byte_off[0] is ignored.
- Scoreboard: one CNT_W-bit counter per register 1..31. Register 0 is never tracked.
  - inc = d_issue & (d_issue_a3 != 0); updates the counter for d_issue_a3.
  - dec = grf_we; updates the counter for grf_a3.
  - Counters update at posedge.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc on a saturated counter: counter holds, sb_err <= 1.
  - dec on a zero counter: counter holds, sb_err <= 1.
  - sb_err clears only on reset.
- busy_x, combinational:
  - busy_x = (d_x != 0) & ((cnt[d_x] - (grf_we & grf_a3 == d_x)) != 0).
  - Rationale: the GRF bypasses a same-cycle write, so the committing write does not count.
  - d_x == 0 → busy_x = 0.
- A bubble (m_valid=0) gives grf_we=0 on the next cycle. grf_pc and grf_wd still update, but are don't-care.

Decomposition:
- Shared package wb_pkg:
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC8).
  - ld_type encodings (LD_W, LD_B, LD_BU, LD_H, LD_HU).
  - PC8 offset constant.
- Sub-module w_load_ext: combinational load extraction/extension (word, type, offset → 32-bit value). It is reused by any future M-stage load path.

Test Plan:
1. Reset released; cycle 1 sees m_valid=1, m_we=1, m_a3=5, WB_ALU, m_alu=32'hDEAD_BEEF, m_pc=32'h3000 → cycle 2: grf_we=1, grf_a3=5, grf_wd=DEADBEEF, grf_pc=3000.
2. MEM source, m_mem_word=32'h8070_F0A1:
   - LB, off=1 → grf_wd=FFFF_FFF0.
   - LBU, off=3 → 0000_0080.
   - LH, off=2 → FFFF_8070.
   - LHU, off=0 → 0000_F0A1.
3. WB_PC8, m_pc=32'hFFFF_FFFC → grf_wd=0000_0004; m_a3=0 with m_we=1 → grf_we=0 and no counter change.
4. Scoreboard:
   - d_issue a3=7 → next cycle busy_rs=1 (d_rs=7).
   - W commits a3=7 → busy_rs=0 in the commit cycle, counter 0 after the edge.
   - Issue and commit of 7 in the same cycle → counter unchanged.
5. Four issues to register 9 with no commit (CNT_W=2) → counter holds at 3, sb_err=1. A commit to register 9 with its counter at 0 also sets sb_err.
6. reset asserted asynchronously while grf_we=1 and counters are nonzero → outputs go to reset values without a clock edge; busy_rs=busy_rt=0 and sb_err=0.
